// File: rtl/ipbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipbus_pkg
// Description : Shared IPbus widths, slave FSM state encoding and bus records
//               used by IPbus slaves and their test masters.
// Revision    : 1.0  initial release
// ============================================================================
package ipbus_pkg;

  localparam int IPB_DATA_W = 32;
  localparam int IPB_ADDR_W = 32;

  // Slave transaction sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } ipb_slv_state_t;

  // Master-to-slave request record
  typedef struct packed {
    logic [IPB_ADDR_W-1:0] addr;
    logic [IPB_DATA_W-1:0] wdata;
    logic                  strobe;
    logic                  write;
  } ipb_wbus_t;

  // Slave-to-master response record
  typedef struct packed {
    logic [IPB_DATA_W-1:0] rdata;
    logic                  ack;
    logic                  err;
  } ipb_rbus_t;

endpackage
`default_nettype wire

// File: rtl/ipbus_regfile_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : ipbus_regfile_slave_if
// Description : IPbus request/response signal bundle with master and slave
//               views.
// Revision    : 1.0  initial release
// ============================================================================
interface ipbus_regfile_slave_if;
  import ipbus_pkg::*;

  logic                  ipb_strobe;
  logic                  ipb_write;
  logic [IPB_ADDR_W-1:0] ipb_addr;
  logic [IPB_DATA_W-1:0] ipb_wdata;
  logic [IPB_DATA_W-1:0] ipb_rdata;
  logic                  ipb_ack;
  logic                  ipb_err;

  modport master (
    output ipb_strobe, ipb_write, ipb_addr, ipb_wdata,
    input  ipb_rdata, ipb_ack, ipb_err
  );

  modport slave (
    input  ipb_strobe, ipb_write, ipb_addr, ipb_wdata,
    output ipb_rdata, ipb_ack, ipb_err
  );

endinterface
`default_nettype wire

// File: rtl/ipbus_addr_decode.sv
`default_nettype none
// ============================================================================
// Module      : ipbus_addr_decode
// Description : Combinational register-bank decode. Turns a word offset and
//               the write flag into one-hot control/status selects plus an
//               error flag (status write or unmapped offset).
// Revision    : 1.0  initial release
// ============================================================================
module ipbus_addr_decode #(
  parameter int N_CTRL     = 8,
  parameter int N_STAT     = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  wire logic [ADDR_WIDTH-1:0] offset,
  input  wire logic                  write,
  output logic      [N_CTRL-1:0]     ctrl_sel,
  output logic      [N_STAT-1:0]     stat_sel,
  output logic                       is_err
);

  // Offset compare against every mapped register; status writes are refused
  always_comb begin
    ctrl_sel = '0;
    stat_sel = '0;
    for (int i = 0; i < N_CTRL; i++) begin
      if (offset == ADDR_WIDTH'(i)) ctrl_sel[i] = 1'b1;
    end
    for (int j = 0; j < N_STAT; j++) begin
      if (offset == ADDR_WIDTH'(N_CTRL + j)) stat_sel[j] = 1'b1;
    end
    is_err = ~((|ctrl_sel) | (|stat_sel)) | (write & (|stat_sel));
  end

endmodule
`default_nettype wire

// File: rtl/ipbus_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : ipbus_regfile_slave
// Description : IPbus responder with N_CTRL read/write control registers and
//               N_STAT read-only status registers. Captures a strobed request,
//               waits WAIT_CYCLES, then answers with a one-cycle ack or err.
// Revision    : 1.0  initial release
// ============================================================================
module ipbus_regfile_slave
  import ipbus_pkg::*;
#(
  parameter int N_CTRL      = 8,
  parameter int N_STAT      = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic                       ipb_clk,
  input  wire logic                       ipb_rst,
  ipbus_regfile_slave_if.slave            bus,
  output logic      [N_CTRL*IPB_DATA_W-1:0] ctrl_q,
  output logic      [N_CTRL-1:0]          ctrl_wr,
  input  wire logic [N_STAT*IPB_DATA_W-1:0] stat_d
);

  localparam logic [3:0] c_wait_init = 4'(WAIT_CYCLES);

  if ((N_CTRL + N_STAT) > (2 ** ADDR_WIDTH)) begin : g_map_check
    $error("ipbus_regfile_slave: N_CTRL+N_STAT exceeds 2**ADDR_WIDTH");
  end
  if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_wait_check
    $error("ipbus_regfile_slave: WAIT_CYCLES must be 0..15");
  end

  ipb_slv_state_t        r_state;
  ipb_slv_state_t        w_state_nxt;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_off;
  logic                  r_write;
  logic [IPB_DATA_W-1:0] r_wdata;
  logic [IPB_DATA_W-1:0] r_stat_word;
  logic [IPB_DATA_W-1:0] r_ctrl [N_CTRL];
  logic [IPB_DATA_W-1:0] r_rdata;
  logic                  r_ack;
  logic                  r_err;
  logic [N_CTRL-1:0]     r_ctrl_wr;

  logic [ADDR_WIDTH-1:0] w_sel_off;
  logic                  w_sel_write;
  logic [N_CTRL-1:0]     w_ctrl_sel;
  logic [N_STAT-1:0]     w_stat_sel;
  logic                  w_is_err;
  logic [IPB_DATA_W-1:0] w_ctrl_word;
  logic [IPB_DATA_W-1:0] w_stat_word;
  logic                  w_unused_addr;

  // Upper address bits are owned by the address-select fabric
  assign w_unused_addr = ^bus.ipb_addr[IPB_ADDR_W-1:ADDR_WIDTH];

  // In IDLE the live request is decoded so a zero-wait transaction can
  // capture status on the same edge it enters RESP; otherwise the latched one
  assign w_sel_off   = (r_state == IDLE) ? bus.ipb_addr[ADDR_WIDTH-1:0] : r_off;
  assign w_sel_write = (r_state == IDLE) ? bus.ipb_write : r_write;

  ipbus_addr_decode #(
    .N_CTRL     (N_CTRL),
    .N_STAT     (N_STAT),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_decode (
    .offset   (w_sel_off),
    .write    (w_sel_write),
    .ctrl_sel (w_ctrl_sel),
    .stat_sel (w_stat_sel),
    .is_err   (w_is_err)
  );

  // One-hot read multiplexers for control and status words
  always_comb begin
    w_ctrl_word = '0;
    w_stat_word = '0;
    for (int i = 0; i < N_CTRL; i++) begin
      if (w_ctrl_sel[i]) w_ctrl_word = w_ctrl_word | r_ctrl[i];
    end
    for (int j = 0; j < N_STAT; j++) begin
      if (w_stat_sel[j]) w_stat_word = w_stat_word | stat_d[IPB_DATA_W*j +: IPB_DATA_W];
    end
  end

  // Next-state logic; RESP is entered when the final wait cycle is running
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.ipb_strobe) w_state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
      end
      WAIT: begin
        if (!bus.ipb_strobe)     w_state_nxt = IDLE;
        else if (r_cnt <= 4'd1)  w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register, request capture, wait counter and status snapshot
  always_ff @(posedge ipb_clk) begin
    if (ipb_rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_off       <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_stat_word <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && bus.ipb_strobe) begin
        r_off   <= bus.ipb_addr[ADDR_WIDTH-1:0];
        r_write <= bus.ipb_write;
        r_wdata <= bus.ipb_wdata;
        r_cnt   <= c_wait_init;
      end else if (r_state == WAIT && bus.ipb_strobe && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_state_nxt == RESP && r_state != RESP) r_stat_word <= w_stat_word;
    end
  end

  // Response generation and control register update, visible with the ack
  always_ff @(posedge ipb_clk) begin
    if (ipb_rst) begin
      r_rdata   <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_ctrl_wr <= '0;
      for (int i = 0; i < N_CTRL; i++) r_ctrl[i] <= '0;
    end else begin
      r_rdata   <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_ctrl_wr <= '0;
      if (r_state == RESP) begin
        if (w_is_err) begin
          r_err <= 1'b1;
        end else begin
          r_ack <= 1'b1;
          if (r_write) begin
            r_ctrl_wr <= w_ctrl_sel;
            for (int i = 0; i < N_CTRL; i++) begin
              if (w_ctrl_sel[i]) r_ctrl[i] <= r_wdata;
            end
          end else begin
            r_rdata <= (|w_ctrl_sel) ? w_ctrl_word : r_stat_word;
          end
        end
      end
    end
  end

  for (genvar i = 0; i < N_CTRL; i++) begin : g_ctrl_pack
    assign ctrl_q[IPB_DATA_W*i +: IPB_DATA_W] = r_ctrl[i];
  end

  assign ctrl_wr       = r_ctrl_wr;
  assign bus.ipb_rdata = r_rdata;
  assign bus.ipb_ack   = r_ack;
  assign bus.ipb_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ipbus_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipbus_regfile_slave
// Description : Directed, table-driven bench for ipbus_regfile_slave with a
//               WAIT_CYCLES=1 instance and a WAIT_CYCLES=3 instance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ipbus_regfile_slave;
  import ipbus_pkg::*;

  localparam int N_CTRL = 8;
  localparam int N_STAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  logic [N_CTRL*32-1:0] ctrl_q1, ctrl_q3;
  logic [N_CTRL-1:0]    ctrl_wr1, ctrl_wr3;
  logic [N_STAT*32-1:0] stat_d;

  ipbus_regfile_slave_if bus1();
  ipbus_regfile_slave_if bus3();

  ipbus_regfile_slave #(.N_CTRL(N_CTRL), .N_STAT(N_STAT), .ADDR_WIDTH(4), .WAIT_CYCLES(1)) dut1 (
    .ipb_clk(clk), .ipb_rst(rst1), .bus(bus1), .ctrl_q(ctrl_q1), .ctrl_wr(ctrl_wr1), .stat_d(stat_d)
  );

  ipbus_regfile_slave #(.N_CTRL(N_CTRL), .N_STAT(N_STAT), .ADDR_WIDTH(4), .WAIT_CYCLES(3)) dut3 (
    .ipb_clk(clk), .ipb_rst(rst3), .bus(bus3), .ctrl_q(ctrl_q3), .ctrl_wr(ctrl_wr3), .stat_d(stat_d)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        ack;
    logic        err;
    logic [31:0] rd;
    logic [7:0]  cw;
  } vec_t;

  vec_t vt [13];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the WAIT_CYCLES=1 slave; lat = cycles until response
  task automatic txn1(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output logic a, output logic e, output logic [31:0] rd,
                      output logic [7:0] cw, output int lat);
    bus1.ipb_strobe = 1'b1;
    bus1.ipb_write  = wr;
    bus1.ipb_addr   = addr;
    bus1.ipb_wdata  = wd;
    a = 1'b0; e = 1'b0; rd = '0; cw = '0; lat = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus1.ipb_ack || bus1.ipb_err) begin
        a = bus1.ipb_ack; e = bus1.ipb_err; rd = bus1.ipb_rdata; cw = ctrl_wr1; lat = c;
        break;
      end
    end
    bus1.ipb_strobe = 1'b0;
    tick();
  endtask

  // One transaction on the WAIT_CYCLES=3 slave, watching every cycle
  task automatic txn3(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      output int first, output int hits, output logic e,
                      output logic [31:0] rd, output logic [7:0] cw);
    bus3.ipb_strobe = 1'b1;
    bus3.ipb_write  = wr;
    bus3.ipb_addr   = addr;
    bus3.ipb_wdata  = wd;
    first = 0; hits = 0; e = 1'b0; rd = '0; cw = '0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (bus3.ipb_ack || bus3.ipb_err) begin
        hits++;
        if (first == 0) begin
          first = c; e = bus3.ipb_err; rd = bus3.ipb_rdata; cw = ctrl_wr3;
        end
        bus3.ipb_strobe = 1'b0;
      end
    end
    bus3.ipb_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        a, e;
    logic [31:0] rd;
    logic [7:0]  cw;
    int          lat, first, hits, nack, last;

    vt[0]  = '{1'b1, 32'h0000_0002, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,         8'h04};
    vt[1]  = '{1'b0, 32'h0000_0002, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF,  8'h00};
    vt[2]  = '{1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 32'h0,         8'h00};
    vt[3]  = '{1'b0, 32'h0000_0009, 32'h0,        1'b1, 1'b0, 32'h12345678,  8'h00};
    vt[4]  = '{1'b1, 32'h0000_0009, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h0,         8'h00};
    vt[5]  = '{1'b0, 32'h0000_000F, 32'h0,        1'b0, 1'b1, 32'h0,         8'h00};
    vt[6]  = '{1'b0, 32'h0000_0008, 32'h0,        1'b1, 1'b0, 32'hA5A50001,  8'h00};
    vt[7]  = '{1'b0, 32'h0000_000B, 32'h0,        1'b1, 1'b0, 32'hC0FFEE03,  8'h00};
    vt[8]  = '{1'b1, 32'h0000_0007, 32'h13579BDF, 1'b1, 1'b0, 32'h0,         8'h80};
    vt[9]  = '{1'b0, 32'h0000_0017, 32'h0,        1'b1, 1'b0, 32'h13579BDF,  8'h00};
    vt[10] = '{1'b0, 32'h0000_000C, 32'h0,        1'b0, 1'b1, 32'h0,         8'h00};
    vt[11] = '{1'b1, 32'hABC0_0010, 32'h00000011, 1'b1, 1'b0, 32'h0,         8'h01};
    vt[12] = '{1'b0, 32'h0000_0000, 32'h0,        1'b1, 1'b0, 32'h00000011,  8'h00};

    stat_d = {32'hC0FFEE03, 32'h0BADF00D, 32'h12345678, 32'hA5A50001};
    bus1.ipb_strobe = 1'b0; bus1.ipb_write = 1'b0; bus1.ipb_addr = '0; bus1.ipb_wdata = '0;
    bus3.ipb_strobe = 1'b0; bus3.ipb_write = 1'b0; bus3.ipb_addr = '0; bus3.ipb_wdata = '0;
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (3) tick();
    rst1 = 1'b0; rst3 = 1'b0;
    tick();

    chk("rst ack1",   bus1.ipb_ack,   1'b0);
    chk("rst err1",   bus1.ipb_err,   1'b0);
    chk("rst rdata1", bus1.ipb_rdata, 32'h0);
    chk("rst ctrl_q1", ctrl_q1, '0);
    chk("rst ctrl_wr1", ctrl_wr1, 8'h0);
    chk("rst ack3",   bus3.ipb_ack,   1'b0);
    chk("rst ctrl_q3", ctrl_q3, '0);

    // Table of single transactions on the one-wait slave
    for (int i = 0; i < 13; i++) begin
      txn1(vt[i].wr, vt[i].addr, vt[i].wd, a, e, rd, cw, lat);
      chk($sformatf("v%0d ack", i),     a,   vt[i].ack);
      chk($sformatf("v%0d err", i),     e,   vt[i].err);
      chk($sformatf("v%0d rdata", i),   rd,  vt[i].rd);
      chk($sformatf("v%0d ctrl_wr", i), cw,  vt[i].cw);
      chk($sformatf("v%0d latency", i), lat, 3);
    end
    chk("table ctrl_q1", ctrl_q1,
        {32'h13579BDF, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h00000011});

    // Strobe held across four writes, new request presented on each ack
    bus1.ipb_strobe = 1'b1; bus1.ipb_write = 1'b1; bus1.ipb_addr = 32'd0; bus1.ipb_wdata = 32'd1;
    nack = 0; last = 0;
    for (int c = 1; c <= 40 && nack < 4; c++) begin
      tick();
      if (bus1.ipb_ack) begin
        chk($sformatf("b2b ctrl_wr%0d", nack), ctrl_wr1, 8'(1 << nack));
        if (nack > 0) chk($sformatf("b2b gap%0d", nack), c - last, 3);
        last = c;
        nack++;
        bus1.ipb_addr  = nack;
        bus1.ipb_wdata = nack + 1;
      end
    end
    bus1.ipb_strobe = 1'b0;
    tick();
    chk("b2b count", nack, 4);
    chk("b2b ctrl_q1", ctrl_q1[127:0], {32'd4, 32'd3, 32'd2, 32'd1});

    // Strobe dropped during WAIT: no response, no register change
    bus1.ipb_strobe = 1'b1; bus1.ipb_write = 1'b1; bus1.ipb_addr = 32'd4; bus1.ipb_wdata = 32'h4444;
    tick();
    bus1.ipb_strobe = 1'b0;
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus1.ipb_ack || bus1.ipb_err || ctrl_wr1 != 8'h0) hits++;
    end
    chk("abort resp", hits, 0);
    chk("abort ctrl4", ctrl_q1[159:128], 32'h0);
    txn1(1'b0, 32'd3, 32'h0, a, e, rd, cw, lat);
    chk("post-abort rdata", rd, 32'd4);

    // Reset on the same edge that would commit a write
    bus1.ipb_strobe = 1'b1; bus1.ipb_write = 1'b1; bus1.ipb_addr = 32'd3; bus1.ipb_wdata = 32'h3333;
    tick();
    tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    bus1.ipb_strobe = 1'b0;
    hits = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus1.ipb_ack || bus1.ipb_err || ctrl_wr1 != 8'h0) hits++;
      tick();
    end
    chk("rstwr resp", hits, 0);
    chk("rstwr ctrl_q1", ctrl_q1, '0);

    // Three-wait slave: exact response cycle and silence elsewhere
    txn3(1'b0, 32'd0, 32'h0, first, hits, e, rd, cw);
    chk("w3 rd cycle", first, 5);
    chk("w3 rd hits", hits, 1);
    chk("w3 rd err", e, 1'b0);
    txn3(1'b1, 32'd5, 32'h0000CAFE, first, hits, e, rd, cw);
    chk("w3 wr cycle", first, 5);
    chk("w3 wr ctrl_wr", cw, 8'h20);
    chk("w3 ctrl5", ctrl_q3[191:160], 32'h0000CAFE);

    // Reset asserted mid-WAIT abandons the transaction silently
    bus3.ipb_strobe = 1'b1; bus3.ipb_write = 1'b1; bus3.ipb_addr = 32'd6; bus3.ipb_wdata = 32'h6666;
    tick();
    tick();
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    bus3.ipb_strobe = 1'b0;
    hits = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus3.ipb_ack || bus3.ipb_err || ctrl_wr3 != 8'h0) hits++;
      tick();
    end
    chk("w3 rst resp", hits, 0);
    chk("w3 rst ctrl_q3", ctrl_q3, '0);
    chk("w3 rst rdata", bus3.ipb_rdata, 32'h0);
    txn3(1'b0, 32'd9, 32'h0, first, hits, e, rd, cw);
    chk("w3 stat cycle", first, 5);
    chk("w3 stat rdata", rd, 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
